// File: rtl/fm_reset_sequencer_pkg.sv
// rtl/fm_reset_sequencer_pkg.sv - shared types and helpers for the reset sequencer
package fm_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_DCM_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STRETCH   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_POR          = 3'd0,
    CAUSE_BUTTON       = 3'd1,
    CAUSE_SW           = 3'd2,
    CAUSE_LOCK_LOST    = 3'd3,
    CAUSE_LOCK_TIMEOUT = 3'd4
  } cause_e;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // Counter width for a modulus n; a modulus of 1 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fm_reset_sequencer_if.sv
// rtl/fm_reset_sequencer_if.sv - board-side signals of the reset sequencer
interface fm_reset_sequencer_if;
  logic       button_in;
  logic       sw_reset_req;
  logic       dcm_locked;
  logic       dcm_reset;
  logic       reset_global;
  logic [2:0] reset_cause;
  logic [7:0] reset_count;

  modport master (
    output button_in, sw_reset_req, dcm_locked,
    input  dcm_reset, reset_global, reset_cause, reset_count
  );

  modport slave (
    input  button_in, sw_reset_req, dcm_locked,
    output dcm_reset, reset_global, reset_cause, reset_count
  );
endinterface

// File: rtl/fm_debounce.sv
// rtl/fm_debounce.sv - level debouncer with a registered rising-edge pulse
module fm_debounce
  import fm_reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level_in,
  output logic level_out,
  output logic rise_pulse
);
  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // Any cycle agreeing with the accepted level restarts the hold window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (level_in != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = level_in;
        rise_d  = level_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
endmodule

// File: rtl/sync_block.sv
// rtl/sync_block.sv - two-flop synchroniser for a single asynchronous bit
module sync_block (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic data_out
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= data_in;
      sync_q <= meta_q;
    end
  end

  assign data_out = sync_q;
endmodule

// File: rtl/fm_reset_sequencer.sv
// rtl/fm_reset_sequencer.sv - MMCM reset, lock wait/retry and reset_global stretch sequencer
module fm_reset_sequencer
  import fm_reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned DCM_RST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1000000,
  parameter int unsigned STRETCH_CYCLES  = 1024
) (
  input  logic                clock_ref,
  input  logic                reset_por_n,
  fm_reset_sequencer_if.slave bus
);
  localparam int unsigned W_DCM  = cnt_width(DCM_RST_CYCLES);
  localparam int unsigned W_LOCK = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned W_STR  = cnt_width(STRETCH_CYCLES);
  localparam int unsigned W_A    = (W_DCM > W_LOCK) ? W_DCM : W_LOCK;
  localparam int unsigned TMR_W  = (W_A > W_STR) ? W_A : W_STR;

  localparam logic [TMR_W-1:0] DCM_LAST     = TMR_W'(DCM_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STRETCH_LAST = TMR_W'(STRETCH_CYCLES - 1);

  logic button_s;
  logic locked_s;
  logic button_level;
  logic press;

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic             dcm_reset_q;
  logic             reset_global_q;
  cause_e           cause_q;
  logic [7:0]       count_q;

  sync_block u_sync_button (
    .clk      (clock_ref),
    .reset_n  (reset_por_n),
    .data_in  (bus.button_in),
    .data_out (button_s)
  );

  sync_block u_sync_locked (
    .clk      (clock_ref),
    .reset_n  (reset_por_n),
    .data_in  (bus.dcm_locked),
    .data_out (locked_s)
  );

  fm_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clock_ref),
    .reset_n    (reset_por_n),
    .level_in   (button_s),
    .level_out  (button_level),
    .rise_pulse (press)
  );

  always_ff @(posedge clock_ref or negedge reset_por_n) begin
    if (!reset_por_n) begin
      state_q        <= ST_DCM_RST;
      timer_q        <= '0;
      dcm_reset_q    <= 1'b1;
      reset_global_q <= 1'b1;
      cause_q        <= CAUSE_POR;
      count_q        <= '0;
    end else begin
      case (state_q)
        ST_DCM_RST: begin
          if (timer_q == DCM_LAST) begin
            state_q     <= ST_WAIT_LOCK;
            timer_q     <= '0;
            dcm_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        // Requests here are ignored; the sequence is already heading for a full reset.
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= ST_STRETCH;
            timer_q <= '0;
          end else if (timer_q == LOCK_LAST) begin
            state_q     <= ST_DCM_RST;
            timer_q     <= '0;
            dcm_reset_q <= 1'b1;
            cause_q     <= CAUSE_LOCK_TIMEOUT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_STRETCH, ST_RUN: begin
          if (!locked_s) begin
            state_q        <= ST_DCM_RST;
            timer_q        <= '0;
            dcm_reset_q    <= 1'b1;
            reset_global_q <= 1'b1;
            cause_q        <= CAUSE_LOCK_LOST;
          end else if (press) begin
            state_q        <= ST_STRETCH;
            timer_q        <= '0;
            reset_global_q <= 1'b1;
            cause_q        <= CAUSE_BUTTON;
          end else if (bus.sw_reset_req) begin
            state_q        <= ST_STRETCH;
            timer_q        <= '0;
            reset_global_q <= 1'b1;
            cause_q        <= CAUSE_SW;
          end else if (state_q == ST_STRETCH) begin
            if (timer_q == STRETCH_LAST) begin
              state_q        <= ST_RUN;
              timer_q        <= '0;
              reset_global_q <= 1'b0;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          if (state_q == ST_RUN && (!locked_s || press || bus.sw_reset_req) &&
              count_q != COUNT_MAX) begin
            count_q <= count_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_DCM_RST;
          timer_q     <= '0;
          dcm_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dcm_reset    = dcm_reset_q;
  assign bus.reset_global = reset_global_q;
  assign bus.reset_cause  = cause_q;
  assign bus.reset_count  = count_q;

  logic unused_level;
  assign unused_level = button_level;
endmodule
